// File: rtl/ctrl_ld_mc.sv
// ctrl_ld_mc -- multi-channel tile load controller.
//
// Each of NUM_CH channels runs a small FSM (IDLE/WAIT/LOAD/DONE). The FSM
// streams cfg_times[i] beats into a buffer, and each beat uses an
// incrementing address. A channel with its chain bit set waits for channel i-1
// to finish before it starts loading. The tile ends when every channel is DONE.
//
// Optional feature: define CTRL_LD_MC_STALL_CNT_EN to count stall cycles.
// In a stall cycle the tile is busy, a channel is in LOAD and its ld_valid is low.
// Without the macro, stall_cycles is tied to zero.
//
// Ports:
//   clk           : clock, rising edge
//   rst_n         : synchronous active-low reset
//   ld_tile_start : tile start pulse (accepted only while idle)
//   cfg_times     : per-channel beat count, CNT_W bits each
//   cfg_dep       : per-channel chain bit (bit 0 ignored)
//   ld_valid      : per-channel data-beat valid
//   ld_ready      : channel is in LOAD
//   ld_en         : per-channel buffer write enable
//   ld_addr       : per-channel buffer write address, ADDR_W bits each
//   busy          : tile in progress
//   start_drop    : pulse when a start is ignored because a tile is busy
//   stall_cycles  : per-tile stall count (zero unless the macro is defined)
//   ld_tile_end   : tile-complete pulse
module ctrl_ld_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_tile_start,
  input  logic [NUM_CH*CNT_W-1:0]  cfg_times,
  input  logic [NUM_CH-1:0]        cfg_dep,
  input  logic [NUM_CH-1:0]        ld_valid,
  output logic [NUM_CH-1:0]        ld_ready,
  output logic [NUM_CH-1:0]        ld_en,
  output logic [NUM_CH*ADDR_W-1:0] ld_addr,
  output logic                     busy,
  output logic                     start_drop,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic                     ld_tile_end
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                  st_q    [NUM_CH];
  state_e                  st_d    [NUM_CH];
  logic [CNT_W-1:0]        cnt_q   [NUM_CH];
  logic [CNT_W-1:0]        cnt_d   [NUM_CH];
  logic [CNT_W-1:0]        times_s [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] times_q;
  logic [NUM_CH*CNT_W-1:0] times_d;
  logic                    busy_q;
  logic                    busy_d;
  logic                    accept_s;
  logic [NUM_CH-1:0]       done_s;
  logic [NUM_CH-1:0]       last_s;
  logic [NUM_CH-1:0]       prev_go_s;
  logic [NUM_CH-1:0]       dep_eff_s;

  assign busy        = busy_q;
  assign accept_s    = ld_tile_start & ~busy_q;
  assign start_drop  = ld_tile_start & busy_q;
  assign ld_tile_end = busy_q & (&done_s);

  // Channel 0 has no predecessor, so its chain bit is forced off.
  assign dep_eff_s = cfg_dep & ~{{(NUM_CH-1){1'b0}}, 1'b1};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign times_s[g]  = times_q[g*CNT_W +: CNT_W];
    assign ld_ready[g] = (st_q[g] == ST_LOAD);
    assign done_s[g]   = (st_q[g] == ST_DONE);
    // A zero-length channel never writes.
    assign ld_en[g]    = ld_ready[g] & ld_valid[g] & (times_s[g] != '0);
    assign last_s[g]   = ld_en[g] & (cnt_q[g] == times_s[g] - CNT_W'(1));
    // The address is the counter truncated, so it wraps modulo 2^ADDR_W.
    assign ld_addr[g*ADDR_W +: ADDR_W] = cnt_q[g][ADDR_W-1:0];
    // A chained channel may start when its predecessor takes its last beat
    // or has already finished.
    if (g == 0) begin : g_first
      assign prev_go_s[g] = 1'b0;
    end else begin : g_rest
      assign prev_go_s[g] = last_s[g-1] | done_s[g-1];
    end
  end

  // Next-state, counter and configuration-latch logic for all channels
  always_comb begin
    busy_d  = busy_q;
    times_d = times_q;
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
    end
    if (accept_s) begin
      busy_d  = 1'b1;
      times_d = cfg_times;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_d[i] = '0;
        st_d[i]  = dep_eff_s[i] ? ST_WAIT : ST_LOAD;
      end
    end else if (ld_tile_end) begin
      busy_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        st_d[i]  = ST_IDLE;
        cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (st_q[i])
          ST_IDLE: st_d[i] = ST_IDLE;
          ST_WAIT: begin
            if (prev_go_s[i]) st_d[i] = ST_LOAD;
            else              st_d[i] = ST_WAIT;
          end
          ST_LOAD: begin
            if (times_s[i] == '0) begin
              st_d[i] = ST_DONE;
            end else if (last_s[i]) begin
              st_d[i]  = ST_DONE;
              cnt_d[i] = '0;
            end else if (ld_en[i]) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
              cnt_d[i] = cnt_q[i];
            end
          end
          ST_DONE: st_d[i] = ST_DONE;
          default: st_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  // State, counter and configuration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      times_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      times_q <= times_d;
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef CTRL_LD_MC_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  // Stall count: cleared on start, saturating, frozen once the tile is idle
  always_comb begin
    stall_d = stall_q;
    if (accept_s) begin
      stall_d = '0;
    end else if (busy_q && (|(ld_ready & ~ld_valid)) && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ctrl_ld_mc.sv
module tb_ctrl_ld_mc;

  logic        clk;
  logic        rst_n;
  logic        ld_tile_start;
  logic [15:0] cfg_times;
  logic [1:0]  cfg_dep;
  logic [1:0]  ld_valid;
  logic [1:0]  ld_ready;
  logic [1:0]  ld_en;
  logic [3:0]  ld_addr;
  logic        busy;
  logic        start_drop;
  logic [7:0]  stall_cycles;
  logic        ld_tile_end;

  int errors = 0;
  int checks = 0;
  logic [31:0] stall_exp;

  ctrl_ld_mc #(.NUM_CH(2), .CNT_W(8), .ADDR_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_tile_start(ld_tile_start),
    .cfg_times    (cfg_times),
    .cfg_dep      (cfg_dep),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .busy         (busy),
    .start_drop   (start_drop),
    .stall_cycles (stall_cycles),
    .ld_tile_end  (ld_tile_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef CTRL_LD_MC_STALL_CNT_EN
    stall_exp = 32'd1;
`else
    stall_exp = 32'd0;
`endif
    // Reset with valid high: nothing may be written while idle.
    rst_n = 1'b0; ld_tile_start = 1'b0; cfg_times = 16'h0000; cfg_dep = 2'b00; ld_valid = 2'b11;
    tick; tick;
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_ready", 32'(ld_ready),     32'd0);
    chk("rst_en",    32'(ld_en),        32'd0);
    chk("rst_addr",  32'(ld_addr),      32'd0);
    chk("rst_end",   32'(ld_tile_end),  32'd0);
    chk("rst_drop",  32'(start_drop),   32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);

    // Parallel load: ch0 4 beats, ch1 3 beats.
    rst_n = 1'b1; cfg_times = {8'd3, 8'd4}; cfg_dep = 2'b00; ld_tile_start = 1'b1; #1;
    chk("t1_drop", 32'(start_drop), 32'd0);
    tick; ld_tile_start = 1'b0; #1;
    chk("t1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_en", 32'(ld_en), (k < 3) ? 32'd3 : 32'd1);
      chk("t1_a0", 32'(ld_addr[1:0]), 32'(k));
      chk("t1_a1", 32'(ld_addr[3:2]), (k < 3) ? 32'(k) : 32'd0);
      tick;
    end
    chk("t1_end",    32'(ld_tile_end), 32'd1);
    chk("t1_en_end", 32'(ld_en),       32'd0);
    tick;
    chk("t1_idle",    32'(busy),        32'd0);
    chk("t1_end_low", 32'(ld_tile_end), 32'd0);

    // Chained load: ch1 waits for ch0 (3 beats), then does 2 beats.
    cfg_times = {8'd2, 8'd3}; cfg_dep = 2'b10; ld_tile_start = 1'b1;
    tick; ld_tile_start = 1'b0; #1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_en",    32'(ld_en),    (k < 3) ? 32'd1 : 32'd2);
      chk("t2_ready", 32'(ld_ready), (k < 3) ? 32'd1 : 32'd2);
      if (k < 3) chk("t2_a0", 32'(ld_addr[1:0]), 32'(k));
      else       chk("t2_a1", 32'(ld_addr[3:2]), 32'(k - 3));
      tick;
    end
    chk("t2_end", 32'(ld_tile_end), 32'd1);
    tick;
    chk("t2_idle", 32'(busy), 32'd0);

    // Zero-length ch1, plus starts while busy and in the tile-end cycle.
    cfg_times = {8'd0, 8'd2}; cfg_dep = 2'b00; ld_tile_start = 1'b1;
    tick; ld_tile_start = 1'b0; #1;
    chk("t3_ready0", 32'(ld_ready),     32'd3);
    chk("t3_en0",    32'(ld_en),        32'd1);
    chk("t3_a0_0",   32'(ld_addr[1:0]), 32'd0);
    tick;
    cfg_times = {8'd5, 8'd5}; ld_tile_start = 1'b1; #1;
    chk("t3_drop_busy", 32'(start_drop),   32'd1);
    chk("t3_ready1",    32'(ld_ready),     32'd1);
    chk("t3_en1",       32'(ld_en),        32'd1);
    chk("t3_a0_1",      32'(ld_addr[1:0]), 32'd1);
    tick;
    chk("t3_end",      32'(ld_tile_end), 32'd1);
    chk("t3_drop_end", 32'(start_drop),  32'd1);
    chk("t3_en_end",   32'(ld_en),       32'd0);
    tick;
    // Start still high in the cycle after tile end: must now be accepted.
    cfg_times = {8'd0, 8'd6}; #1;
    chk("t3_no_accept", 32'(busy),       32'd0);
    chk("t3_drop_idle", 32'(start_drop), 32'd0);
    chk("t3_ready_idle", 32'(ld_ready),  32'd0);

    // Address wrap: 6 beats with a 2-bit address.
    tick; ld_tile_start = 1'b0; #1;
    chk("t4_accepted", 32'(busy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("t4_en", 32'(ld_en),        32'd1);
      chk("t4_a0", 32'(ld_addr[1:0]), 32'(k % 4));
      tick;
    end
    chk("t4_en_after", 32'(ld_en),       32'd0);
    chk("t4_end",      32'(ld_tile_end), 32'd1);
    tick;

    // Reset after two beats abandons the tile.
    cfg_times = {8'd5, 8'd5}; ld_tile_start = 1'b1;
    tick; ld_tile_start = 1'b0; #1;
    chk("t5_a0_0", 32'(ld_addr[1:0]), 32'd0);
    tick;
    chk("t5_a0_1", 32'(ld_addr[1:0]), 32'd1);
    tick;
    rst_n = 1'b0;
    tick; rst_n = 1'b1; #1;
    chk("t5_busy",  32'(busy),     32'd0);
    chk("t5_ready", 32'(ld_ready), 32'd0);
    chk("t5_addr",  32'(ld_addr),  32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_end", 32'(ld_tile_end), 32'd0);
      tick;
    end
    cfg_times = {8'd1, 8'd2}; ld_tile_start = 1'b1;
    tick; ld_tile_start = 1'b0; #1;
    chk("t5_new_en",   32'(ld_en),   32'd3);
    chk("t5_new_addr", 32'(ld_addr), 32'd0);
    tick;
    chk("t5_new_en1", 32'(ld_en),        32'd1);
    chk("t5_new_a0",  32'(ld_addr[1:0]), 32'd1);
    tick;
    chk("t5_new_end", 32'(ld_tile_end), 32'd1);
    tick;

    // Stall: ch0 valid 1,0,1 over a 2-beat tile.
    cfg_times = {8'd0, 8'd2}; ld_valid = 2'b11; ld_tile_start = 1'b1;
    tick; ld_tile_start = 1'b0; #1;
    chk("t6_en0", 32'(ld_en), 32'd1);
    tick;
    ld_valid = 2'b10; #1;
    chk("t6_en_stall", 32'(ld_en),        32'd0);
    chk("t6_a0_stall", 32'(ld_addr[1:0]), 32'd1);
    tick;
    ld_valid = 2'b11; #1;
    chk("t6_en1", 32'(ld_en), 32'd1);
    tick;
    chk("t6_end", 32'(ld_tile_end), 32'd1);
    tick;
    chk("t6_stall",      32'(stall_cycles), stall_exp);
    tick;
    chk("t6_stall_hold", 32'(stall_cycles), stall_exp);
    cfg_times = {8'd0, 8'd1}; ld_tile_start = 1'b1;
    tick; ld_tile_start = 1'b0; #1;
    chk("t6_stall_clr", 32'(stall_cycles), 32'd0);
    tick; tick; tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_ld_mc.md
CTRL_LD_MC -- requirements
Module: ctrl_ld_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent load channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, beat counter and tile-length width.
REQ-003 SHALL have parameter ADDR_W, default 10, buffer address width (ADDR_W <= CNT_W).
REQ-004 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port ld_tile_start  input  1  tile start pulse.
REQ-007 SHALL have port cfg_times  input  NUM_CH*CNT_W  per-channel beat count, latched on an accepted start.
REQ-008 SHALL have port cfg_dep  input  NUM_CH  per-channel chain bit, latched on an accepted start; bit 0 ignored.
REQ-009 SHALL have port ld_valid  input  NUM_CH  per-channel data-beat valid.
REQ-010 SHALL have port ld_ready  output  NUM_CH  channel is in LOAD.
REQ-011 SHALL have port ld_en  output  NUM_CH  buffer write enable.
REQ-012 SHALL have port ld_addr  output  NUM_CH*ADDR_W  buffer write address.
REQ-013 SHALL have port busy  output  1  tile in progress.
REQ-014 SHALL have port start_drop  output  1  one-cycle pulse when a start is ignored.
REQ-015 SHALL have port stall_cycles  output  CNT_W  per-tile stall count.
REQ-016 SHALL have port ld_tile_end  output  1  one-cycle tile-complete pulse.

Function
REQ-017 SHALL implement one FSM per channel with states IDLE, WAIT, LOAD, DONE.
REQ-018 SHALL accept ld_tile_start only when busy=0; on acceptance busy->1 next cycle, cfg latched, all counters cleared.
REQ-019 SHALL, on an accepted start, move channel i IDLE->WAIT if i>0 and cfg_dep[i]=1, else IDLE->LOAD.
REQ-020 SHALL move WAIT->LOAD on the edge where channel i-1 performs its last beat, or on the next edge if channel i-1 is already DONE.
REQ-021 SHALL drive ld_en[i] = (state==LOAD) & ld_valid[i] & (times[i]!=0); ld_valid outside LOAD is ignored.
REQ-022 SHALL drive ld_addr[i] = low ADDR_W bits of beat counter i, combinationally from the registered counter; the counter increments on each ld_en[i].
REQ-023 SHALL treat a beat as last when ld_en[i] & (cnt==times[i]-1), compared at CNT_W bits; on the same edge the counter clears and the channel enters DONE.
REQ-024 SHALL move a LOAD channel with times[i]=0 to DONE on the next edge, with no ld_en pulses.
REQ-025 SHALL assert ld_tile_end combinationally when busy=1 and all channels are DONE; on that edge all channels go IDLE and busy goes to 0.
REQ-026 SHALL ignore ld_tile_start (pulsing start_drop) while busy=1, including the ld_tile_end cycle; a start at busy=0 is accepted the cycle after ld_tile_end.
REQ-027 SHALL drive ld_ready[i]=1 exactly while channel i is in LOAD.
REQ-028 SHALL wrap ld_addr modulo 2^ADDR_W when times exceeds 2^ADDR_W; the counter itself does not wrap before the last beat.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, force all FSMs to IDLE, all counters to 0, busy=0, stall_cycles=0, and all latched cfg to 0.
REQ-030 SHALL make outputs after reset: ld_en=0, ld_ready=0, ld_addr=0, ld_tile_end=0, start_drop=0.
REQ-031 SHALL, on reset mid-tile, abandon the tile with no ld_tile_end pulse.

Configuration
REQ-032 SHALL, when macro CTRL_LD_MC_STALL_CNT_EN is defined, count in stall_cycles the cycles with busy=1, some channel in LOAD and ld_valid low for that channel; the count clears on an accepted start, saturates at all-ones and holds after ld_tile_end.
REQ-033 SHALL, without CTRL_LD_MC_STALL_CNT_EN, tie stall_cycles to 0 and implement no counter logic.

Verification
REQ-034 SHALL cover: NUM_CH=2, times={4,3}, dep=00, ld_valid continuously high -> ch0 addr 0..3, ch1 addr 0..2 in parallel; ld_tile_end 1 cycle after the ch0 last beat.
REQ-035 SHALL cover: times={3,2}, dep[1]=1 -> ch1 enters LOAD on the edge of the ch0 last beat, its first ld_en the next cycle, ld_tile_end after the ch1 last beat.
REQ-036 SHALL cover: times[1]=0, dep=00 -> ch1 never pulses ld_en; the tile ends when ch0 finishes.
REQ-037 SHALL cover: second start while busy=1 and at the ld_tile_end cycle -> start_drop=1 both times, no state change.
REQ-038 SHALL cover: ADDR_W=2, times=6 -> ld_addr 0,1,2,3,0,1; exactly 6 beats.
REQ-039 SHALL cover: rst_n low after 2 beats, then a new start -> addresses restart at 0, no ld_tile_end from the aborted tile; with the macro defined, ld_valid toggled 1,0,1 for a 2-beat tile -> stall_cycles=1.
